// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared types and constants for the instruction fetch unit.
package if_fetch_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int INST_W = 32;
endpackage

// File: rtl/if_fetch_if.sv
// if_fetch_if: memory, redirect and decode-side signals of the fetch unit.
interface if_fetch_if;
    import if_fetch_pkg::*;
    logic              imem_req;
    logic [INST_W-1:0] imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [INST_W-1:0] redirect_pc;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [INST_W-1:0] inst_pc;
    logic              inst_ready;
    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_ack, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_ack, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/if_fetch_inst_fifo.sv
// inst_fifo: registered-head instruction queue with flush; head read straight from storage flops.
module inst_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = din;
                wr_d        = wr_q + 1'b1;
            end
            if (pop) rd_d = rd_q + 1'b1;
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout  = mem_q[rd_q];
    assign full  = cnt_q == CW'(DEPTH);
    assign empty = cnt_q == '0;
    assign count = cnt_q;
endmodule

// File: rtl/if_fetch.sv
// if_fetch: single-outstanding instruction fetcher feeding a decode queue, with redirect and flush.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 4
) (
    input logic clk,
    input logic rst_n,
    if_fetch_if.master bus
);
    localparam int          CW         = $clog2(DEPTH) + 1;
    localparam logic [31:0] RESET_ADDR = RESET_PC & ~32'd3;

    state_e              state_q, state_d;
    logic [31:0]         fetch_pc_q, fetch_pc_d, addr_q, addr_d;
    logic                push, pop, full, empty;
    logic [CW-1:0]       count;
    logic [2*INST_W-1:0] head;

    // A pop in the same cycle never frees a slot for the issue decision.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        push       = 1'b0;
        case (state_q)
            IDLE: if (!bus.redirect_valid && count < CW'(DEPTH)) begin
                state_d = WAIT;
                addr_d  = fetch_pc_q;
            end
            WAIT: if (bus.imem_ack) begin
                state_d = IDLE;
                push    = !bus.redirect_valid && !full;
                if (!bus.redirect_valid) fetch_pc_d = addr_q + 32'd4;
            end else if (bus.redirect_valid) begin
                state_d = DROP;
            end
            DROP: if (bus.imem_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.redirect_valid) fetch_pc_d = bus.redirect_pc & ~32'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_ADDR;
            addr_q     <= RESET_ADDR;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    assign pop = !empty && bus.inst_ready && !bus.redirect_valid;

    inst_fifo #(.WIDTH(2*INST_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .din   ({bus.imem_rdata, addr_q}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign bus.imem_req   = state_q != IDLE;
    assign bus.imem_addr  = addr_q;
    assign bus.inst_valid = !empty;
    assign bus.inst       = head[2*INST_W-1:INST_W];
    assign bus.inst_pc    = head[INST_W-1:0];
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed scenario tests for if_fetch with hand-computed expectations.
module tb_if_fetch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   auto_ack = 1'b0;
    int   tests = 0;
    int   fails = 0;

    if_fetch_if bus ();
    if_fetch dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_ack) begin
            bus.imem_ack   = bus.imem_req;
            bus.imem_rdata = bus.imem_addr ^ 32'hDEAD_0000;
        end
    endtask

    task automatic do_reset(input logic ready, input bit aa);
        rst_n              = 1'b0;
        auto_ack           = aa;
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = ready;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.imem_ack = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.inst_ready = 1'b1;
        tick();
        tests++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %0b want 0", bus.imem_req); end
        tests++; if (bus.imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
        tests++; if (bus.inst_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", bus.inst_valid); end
        tests++; if (bus.inst !== 32'h0 || bus.inst_pc !== 32'h0) begin fails++; $display("FAIL reset_inst: got %h/%h want 0/0", bus.inst, bus.inst_pc); end
        do_reset(1'b1, 1'b0);
        tick();
        tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin fails++; $display("FAIL first_req: got %0b@%h want 1@0", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_stream();
        do_reset(1'b1, 1'b1);
        tick();
        tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin fails++; $display("FAIL stream_a0: got %0b@%h want 1@0", bus.imem_req, bus.imem_addr); end
        tick();
        tests++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst !== 32'hDEAD_0000) begin fails++; $display("FAIL stream_i0: got %0b %h %h want 1 0 dead0000", bus.inst_valid, bus.inst_pc, bus.inst); end
        tests++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL stream_gap: got %0b want 0", bus.imem_req); end
        tick();
        tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin fails++; $display("FAIL stream_a4: got %0b@%h want 1@4", bus.imem_req, bus.imem_addr); end
        tick();
        tests++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h4) begin fails++; $display("FAIL stream_i4: got %0b %h want 1 4", bus.inst_valid, bus.inst_pc); end
        tick();
        tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin fails++; $display("FAIL stream_a8: got %0b@%h want 1@8", bus.imem_req, bus.imem_addr); end
        auto_ack = 1'b0;
        bus.imem_ack = 1'b0;
    endtask

    task automatic test_full();
        int reqs = 0;
        do_reset(1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.imem_req) reqs++;
        end
        tests++; if (reqs !== 4) begin fails++; $display("FAIL full_pushes: got %0d want 4", reqs); end
        tests++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL full_req: got %0b want 0", bus.imem_req); end
        tests++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst !== 32'hDEAD_0000) begin fails++; $display("FAIL full_head: got %0b %h %h want 1 0 dead0000", bus.inst_valid, bus.inst_pc, bus.inst); end
        bus.inst_ready = 1'b1;
        tick();
        tests++; if (bus.imem_req !== 1'b0 || bus.inst_pc !== 32'h4) begin fails++; $display("FAIL full_pop: got req %0b pc %h want 0 4", bus.imem_req, bus.inst_pc); end
        tick();
        tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin fails++; $display("FAIL full_resume: got %0b@%h want 1@10", bus.imem_req, bus.imem_addr); end
        auto_ack = 1'b0;
        bus.imem_ack = 1'b0;
    endtask

    task automatic test_redirect_wait();
        do_reset(1'b0, 1'b0);
        bus.imem_rdata = 32'h1111_1111;
        tick(); bus.imem_ack = 1'b1;
        tick(); bus.imem_ack = 1'b0;
        tick(); bus.imem_ack = 1'b1;
        tick(); bus.imem_ack = 1'b0;
        tick();
        tests++; if (bus.imem_addr !== 32'h8 || bus.inst_valid !== 1'b1) begin fails++; $display("FAIL rw_setup: got addr %h valid %0b want 8 1", bus.imem_addr, bus.inst_valid); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h1002;
        tick();
        bus.redirect_valid = 1'b0;
        tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8 || bus.inst_valid !== 1'b0) begin fails++; $display("FAIL rw_drop: got %0b@%h valid %0b want 1@8 0", bus.imem_req, bus.imem_addr, bus.inst_valid); end
        tick();
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hBAD0_BAD0;
        tick();
        bus.imem_ack = 1'b0;
        tests++; if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin fails++; $display("FAIL rw_discard: got req %0b valid %0b want 0 0", bus.imem_req, bus.inst_valid); end
        tick();
        tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h1000) begin fails++; $display("FAIL rw_target: got %0b@%h want 1@1000", bus.imem_req, bus.imem_addr); end
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'h2222_2222;
        tick();
        bus.imem_ack = 1'b0;
        tests++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h1000 || bus.inst !== 32'h2222_2222) begin fails++; $display("FAIL rw_newinst: got %0b %h %h want 1 1000 22222222", bus.inst_valid, bus.inst_pc, bus.inst); end
    endtask

    task automatic test_redirect_ack();
        do_reset(1'b0, 1'b0);
        tick(); bus.imem_ack = 1'b1;
        tick(); bus.imem_ack = 1'b0;
        tick();
        tests++; if (bus.imem_addr !== 32'h4 || bus.inst_valid !== 1'b1) begin fails++; $display("FAIL ra_setup: got addr %h valid %0b want 4 1", bus.imem_addr, bus.inst_valid); end
        bus.imem_ack = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h2000;
        tick();
        bus.imem_ack = 1'b0;
        bus.redirect_valid = 1'b0;
        tests++; if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin fails++; $display("FAIL ra_nodrop: got req %0b valid %0b want 0 0", bus.imem_req, bus.inst_valid); end
        tick();
        tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h2000) begin fails++; $display("FAIL ra_target: got %0b@%h want 1@2000", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_wrap();
        do_reset(1'b1, 1'b0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFF;
        tick();
        bus.redirect_valid = 1'b0;
        tests++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL wrap_hold: got %0b want 0", bus.imem_req); end
        tick();
        tests++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_top: got %h want fffffffc", bus.imem_addr); end
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        tests++; if (bus.inst_pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_inst: got %h want fffffffc", bus.inst_pc); end
        tick();
        tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_zero: got %0b@%h want 1@0", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_async_reset();
        do_reset(1'b0, 1'b0);
        tick(); bus.imem_ack = 1'b1;
        tick(); bus.imem_ack = 1'b0;
        tick(); bus.imem_ack = 1'b1;
        tick(); bus.imem_ack = 1'b0;
        tick();
        tests++; if (bus.imem_req !== 1'b1 || bus.inst_valid !== 1'b1) begin fails++; $display("FAIL ar_setup: got req %0b valid %0b want 1 1", bus.imem_req, bus.inst_valid); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h0) begin fails++; $display("FAIL ar_async: got req %0b valid %0b addr %h want 0 0 0", bus.imem_req, bus.inst_valid, bus.imem_addr); end
        tick();
        rst_n = 1'b1;
        bus.imem_ack = 1'b1;
        tick();
        tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.inst_valid !== 1'b0) begin fails++; $display("FAIL ar_stale_ack: got %0b@%h valid %0b want 1@0 0", bus.imem_req, bus.imem_addr, bus.inst_valid); end
        bus.imem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect_wait();
        test_redirect_ack();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter DEPTH, default 4, is the instruction queue depth (power of two, >=2).
REQ-003 clock  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  word-aligned fetch address; bits [1:0] always 0.
REQ-007 imem_ack  input  1  memory accepts the request and returns data in the same cycle.
REQ-008 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-009 redirect_valid  input  1  branch/jump redirect from execute, one-cycle pulse.
REQ-010 redirect_pc  input  32  new fetch address; bits [1:0] ignored and treated as 0.
REQ-011 inst_valid  output  1  queue head holds a valid instruction for decode.
REQ-012 inst  output  32  queue-head instruction word (op/rs/rt/rd/funct fields for decode).
REQ-013 inst_pc  output  32  address of the queue-head instruction.
REQ-014 inst_ready  input  1  decode consumes head when inst_valid && inst_ready.

Function
REQ-015 Requester FSM SHALL have states IDLE, WAIT and DROP.
REQ-016 IDLE: when (count + 0) < DEPTH and no redirect this cycle, assert imem_req with imem_addr=fetch_pc and go to WAIT; otherwise stay with imem_req=0.
REQ-017 WAIT: imem_req and imem_addr held stable until imem_ack; at most one request outstanding.
REQ-018 WAIT with imem_ack and no redirect: push {imem_rdata, imem_addr} into queue, fetch_pc += 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), return to IDLE.
REQ-019 WAIT with redirect_valid and no imem_ack: go to DROP, keeping imem_req and the old imem_addr stable.
REQ-020 DROP: on imem_ack discard imem_rdata, no push, return to IDLE.
REQ-021 Redirect in any state SHALL set fetch_pc = {redirect_pc[31:2],2'b00} and flush the queue (count=0) in that cycle; a pop in the same cycle is ignored.
REQ-022 Redirect coincident with imem_ack in WAIT SHALL discard that data and return to IDLE (no DROP).
REQ-023 Redirect in DROP SHALL update fetch_pc; state remains DROP until ack.
REQ-024 Queue: FIFO of DEPTH entries; simultaneous push and pop keeps count unchanged; push never occurs when full (guaranteed by REQ-016 since requests only issue when count < DEPTH - outstanding).
REQ-025 Issue condition precisely: request issued only if count < DEPTH, counting a pop in the same cycle as freeing no slot (conservative).
REQ-026 inst_valid = (count != 0); inst/inst_pc are the head entry, registered, no combinational path from imem_* to inst_*.
REQ-027 Fetch-to-decode latency: ack in cycle N -> inst_valid at N+1 when queue was empty.
REQ-028 Throughput: with imem_ack asserted every cycle that imem_req is high, and decode always ready, one instruction every 2 cycles.

Reset
REQ-029 While reset=0: state=IDLE, fetch_pc=RESET_PC, count=0, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
REQ-030 Reset asserted mid-WAIT SHALL drop the outstanding request; an ack arriving after release while in IDLE is ignored.
REQ-031 First request SHALL be issued in the first clock edge after reset deasserts.

Structure
REQ-032 Shared package SHALL hold the FSM state enum (IDLE/WAIT/DROP), RESET_PC default and instruction width constant 32.
REQ-033 Queue SHALL be a separate sub-module inst_fifo (params WIDTH, DEPTH; push, pop, flush, full, empty, count).

Verification
REQ-034 Reset release, ack every cycle, ready=1 -> imem_addr sequence 0x0,0x4,0x8; inst_pc follows one cycle after each ack.
REQ-035 inst_ready=0, acks always -> exactly 4 pushes, then imem_req stays 0; inst_valid=1, inst_pc=0x0 held.
REQ-036 Redirect to 0x1002 while WAIT on 0x8, ack two cycles later -> data discarded, next imem_addr=0x1000, queue empty.
REQ-037 Redirect coincident with ack of 0x4 -> no push, next imem_addr=redirect target, no DROP visited.
REQ-038 fetch_pc=0xFFFF_FFFC acked -> next imem_addr=0x0000_0000.
REQ-039 reset=0 mid-WAIT with 2 queued entries -> imem_req=0, inst_valid=0 immediately (asynchronous).
